// File: rtl/burst_host_pkg.sv
// burst_host_pkg
// Shared definitions for the burst host: FSM state encoding, default
// sizing parameters and the FIFO occupancy-count width helper.
// Optional build macro used by burst_host: BURST_HOST_CHECK_EN.
package burst_host_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;

    // state   | meaning
    // IDLE    | waiting for go with a non-empty TX FIFO
    // SEND    | streaming N bytes toward the engine
    // GAP     | one quiet cycle marking end of burst
    // WAIT    | waiting for RX room and the first returned byte
    // RECV    | collecting the remaining returned bytes
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_t;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/burst_host_fifo.sv
// host_fifo
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request and data; dropped when full unless a pop
//                   frees a slot in the same cycle
//   pop             read request; ignored when empty
//   head            current head entry, 0 when empty
//   count           occupancy, 0..DEPTH
module host_fifo
    import burst_host_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW = count_width(DEPTH),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/burst_host.sv
// burst_host
// Host-side agent for the byte-burst reversal interface. Bytes loaded into
// the TX FIFO are sent as one burst on din/i_valid after go; the reversed
// burst coming back on dout/o_valid is paced with busy and stored in the
// RX FIFO for the controller.
// Build macro: BURST_HOST_CHECK_EN - when defined, a shadow stack of the
// sent bytes checks the returned order and raises err_mismatch; otherwise
// err_mismatch is tied low.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wr_data, wr_en             TX FIFO load
//   go                         start-burst pulse
//   din, i_valid               burst toward the engine
//   dout, o_valid, busy        returned burst and host flow control
//   rd_en, rd_data             RX FIFO pop / FWFT head
//   tx_count, rx_count         FIFO occupancies
//   done                       one-cycle burst-complete pulse
//   err_overflow/timeout/mismatch  sticky error flags
module burst_host
    import burst_host_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             go,
    output logic [WIDTH-1:0] din,
    output logic             i_valid,
    input  logic [WIDTH-1:0] dout,
    input  logic             o_valid,
    output logic             busy,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    tx_count,
    output logic [CW-1:0]    rx_count,
    output logic             done,
    output logic             err_overflow,
    output logic             err_timeout,
    output logic             err_mismatch
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [CW-1:0]    n_len;
    logic [CW-1:0]    sent;
    logic [CW-1:0]    rcvd;
    logic [TW-1:0]    idle_tmr;
    logic [WIDTH-1:0] tx_head;
    logic             start;
    logic             tx_pop;
    logic             rx_take;
    logic             overflow;
    logic             room;

    assign start    = (state == ST_IDLE) && go && (tx_count != '0);
    assign tx_pop   = start || ((state == ST_SEND) && (sent != n_len));
    assign rx_take  = o_valid && ((state == ST_WAIT) || (state == ST_RECV));
    // A pop in the same cycle frees the slot, so that write is not lost.
    assign overflow = wr_en && (tx_count == CW'(DEPTH)) && !tx_pop;
    assign room     = (CW'(DEPTH) - rx_count) >= n_len;

    host_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    host_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_take),
        .push_data (dout),
        .pop       (rd_en),
        .head      (rd_data),
        .count     (rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            din          <= '0;
            i_valid      <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            n_len        <= '0;
            sent         <= '0;
            rcvd         <= '0;
            idle_tmr     <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    busy <= 1'b1;
                    if (start) begin
                        n_len   <= tx_count;
                        sent    <= CW'(1);
                        din     <= tx_head;
                        i_valid <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sent == n_len) begin
                        din     <= '0;
                        i_valid <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        din  <= tx_head;
                        sent <= sent + CW'(1);
                    end
                end
                ST_GAP: begin
                    idle_tmr <= TW'(TIMEOUT);
                    rcvd     <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT, ST_RECV: begin
                    if (o_valid) begin
                        idle_tmr <= TW'(TIMEOUT);
                        rcvd     <= rcvd + CW'(1);
                        if (rcvd + CW'(1) == n_len) begin
                            busy  <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_RECV;
                        end
                    end else if (idle_tmr == TW'(1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        idle_tmr <= idle_tmr - TW'(1);
                        // Once receiving, the engine is committed; only WAIT gates on room.
                        busy     <= (state == ST_WAIT) ? !room : 1'b0;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b1;
                    i_valid <= 1'b0;
                    din     <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BURST_HOST_CHECK_EN
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] shadow [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = AW'(sp - CW'(1));

    // Sent bytes go on a stack; returned bytes must pop off in reverse order.
    // Each new burst restarts the stack so a timed-out burst leaves no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp           <= '0;
            err_mismatch <= 1'b0;
        end else if (start) begin
            shadow[0] <= tx_head;
            sp        <= CW'(1);
        end else if (tx_pop) begin
            shadow[wr_idx] <= tx_head;
            sp             <= sp + CW'(1);
        end else if (rx_take) begin
            if ((sp == '0) || (dout != shadow[rd_idx])) begin
                err_mismatch <= 1'b1;
            end
            if (sp != '0) begin
                sp <= sp - CW'(1);
            end
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_burst_host.sv
module tb_burst_host;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(DEPTH) + 1;
`ifdef BURST_HOST_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef logic [7:0] byteq_t[$];

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             go;
    logic [WIDTH-1:0] din;
    logic             i_valid;
    logic [WIDTH-1:0] dout;
    logic             o_valid;
    logic             busy;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    tx_count;
    logic [CW-1:0]    rx_count;
    logic             done;
    logic             err_overflow;
    logic             err_timeout;
    logic             err_mismatch;

    burst_host #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .go           (go),
        .din          (din),
        .i_valid      (i_valid),
        .dout         (dout),
        .o_valid      (o_valid),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .done         (done),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_mismatch (err_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model of the RX FIFO contents, in arrival order.
    logic [7:0] rx_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; go = 1'b0;
        o_valid = 1'b0; dout = '0; rd_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic load(input byteq_t b);
        foreach (b[i]) begin
            wr_en = 1'b1; wr_data = b[i];
            tick();
        end
        wr_en = 1'b0; wr_data = '0;
    endtask

    // Pulse go and follow the outgoing burst, ending on the GAP cycle sample.
    task automatic send_burst(input byteq_t exp);
        go = 1'b1;
        tick();
        go = 1'b0;
        foreach (exp[i]) begin
            chk("din_valid", {31'd0, i_valid}, 32'd1);
            chk("din_byte", {24'd0, din}, {24'd0, exp[i]});
            tick();
        end
        chk("gap_ivalid", {31'd0, i_valid}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_din", {24'd0, din}, 32'd0);
    endtask

    // Behave as the engine: wait for busy low, return bytes back to back.
    task automatic respond(input byteq_t ret, input bit rand_rd);
        int w;
        int extra;
        w = 0;
        while (busy && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) begin
            chk("busy_wait_expired", 32'd1, 32'd0);
            return;
        end
        extra = 0;
        foreach (ret[i]) begin
            o_valid = 1'b1;
            dout    = ret[i];
            rd_en   = rand_rd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rd_en && rx_q.size() > 0)
                chk("rd_head_in_burst", {24'd0, rd_data}, {24'd0, rx_q[0]});
            tick();
            if (rd_en && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_q.push_back(ret[i]);
            if (i < ret.size() - 1 && done) extra++;
        end
        o_valid = 1'b0; dout = '0; rd_en = 1'b0;
        chk("done_after_last", {31'd0, done}, 32'd1);
        tick();
        if (done) extra++;
        chk("done_single_pulse", extra, 32'd0);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        chk("rd_head", {24'd0, rd_data}, {24'd0, rx_q[0]});
        tick();
        rd_en = 1'b0;
        void'(rx_q.pop_front());
    endtask

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] stride;
        bit         corrupt;
        int         exp_rx;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byteq_t s;
        byteq_t r;

        vt[0] = '{3,  8'h11, 8'h11, 1'b0, 3,  8'h33};
        vt[1] = '{1,  8'hA0, 8'h01, 1'b0, 1,  8'hA0};
        vt[2] = '{16, 8'h00, 8'h01, 1'b0, 16, 8'h0F};
        vt[3] = '{5,  8'hF0, 8'h03, 1'b1, 5,  8'hFC};
        vt[4] = '{3,  8'h11, 8'h11, 1'b1, 3,  8'h33};

        do_reset();
        chk("rst_din", {24'd0, din}, 32'd0);
        chk("rst_ivalid", {31'd0, i_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_tx_count", {27'd0, tx_count}, 32'd0);
        chk("rst_rx_count", {27'd0, rx_count}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_errs", {29'd0, err_overflow, err_timeout, err_mismatch}, 32'd0);

        // Table-driven bursts: bytes base + stride*i, returned reversed.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            s.delete(); r.delete();
            for (int i = 0; i < vt[v].n; i++) s.push_back(8'(vt[v].base + vt[v].stride * i));
            for (int i = vt[v].n - 1; i >= 0; i--) r.push_back(s[i]);
            if (vt[v].corrupt) r[vt[v].n - 1] = r[vt[v].n - 1] + 8'd1;
            load(s);
            chk("tbl_tx_count", {27'd0, tx_count}, vt[v].n);
            send_burst(s);
            respond(r, 1'b0);
            chk("tbl_rx_count", {27'd0, rx_count}, vt[v].exp_rx);
            chk("tbl_rd_data", {24'd0, rd_data}, {24'd0, vt[v].exp_rd});
            chk("tbl_mismatch", {31'd0, err_mismatch}, {31'd0, CHECK & vt[v].corrupt});
            tick(); tick(); tick();
            chk("tbl_mismatch_sticky", {31'd0, err_mismatch}, {31'd0, CHECK & vt[v].corrupt});
            chk("tbl_timeout", {31'd0, err_timeout}, 32'd0);
        end

        // RX flow control: 14 bytes held, burst of 3 needs one pop.
        do_reset();
        s.delete(); r.delete();
        for (int i = 0; i < 14; i++) s.push_back(8'(8'h40 + i));
        for (int i = 13; i >= 0; i--) r.push_back(s[i]);
        load(s); send_burst(s); respond(r, 1'b0);
        chk("fc_rx14", {27'd0, rx_count}, 32'd14);
        s = '{8'h71, 8'h72, 8'h73};
        load(s); send_burst(s);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fc_busy_held", {31'd0, busy}, 32'd1);
        end
        pop_one();
        chk("fc_busy_same", {31'd0, busy}, 32'd1);
        chk("fc_rx13", {27'd0, rx_count}, 32'd13);
        tick();
        chk("fc_busy_fall", {31'd0, busy}, 32'd0);
        respond('{8'h73, 8'h72, 8'h71}, 1'b0);
        chk("fc_rx16", {27'd0, rx_count}, 32'd16);

        // Timeout after a 2-byte burst with no response.
        do_reset();
        s = '{8'hC1, 8'hC2};
        load(s); send_burst(s);
        repeat (50) tick();
        chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
        repeat (20) tick();
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd1);
        s = '{8'h5A};
        load(s); send_burst(s);
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);

        // Overflow at the 17th write, then a full 16-byte burst.
        do_reset();
        s.delete();
        for (int i = 0; i < 16; i++) s.push_back(8'(8'h80 + i));
        load(s);
        chk("ov_full_noerr", {31'd0, err_overflow}, 32'd0);
        load('{8'hEE});
        chk("ov_tx16", {27'd0, tx_count}, 32'd16);
        chk("ov_flag", {31'd0, err_overflow}, 32'd1);
        send_burst(s);
        chk("ov_tx_empty", {27'd0, tx_count}, 32'd0);

        // Reset during the second byte of a 5-byte burst.
        do_reset();
        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load(s);
        go = 1'b1; tick(); go = 1'b0;
        tick();
        chk("rs_byte2", {24'd0, din}, 32'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_ivalid", {31'd0, i_valid}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd1);
        chk("rs_tx_count", {27'd0, tx_count}, 32'd0);
        chk("rs_din", {24'd0, din}, 32'd0);
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rs_go_ignored", {31'd0, i_valid}, 32'd0);
            tick();
        end

        // Random bursts against the queue model, with stray bytes and pops.
        do_reset();
        for (int it = 0; it < 25; it++) begin
            int len;
            int pops;
            pops = $urandom_range(0, 3);
            for (int p = 0; p < pops && rx_q.size() > 0; p++) pop_one();
            if (rx_q.size() == 0 && $urandom_range(0, 1)) begin
                rd_en = 1'b1; tick(); rd_en = 1'b0;
                chk("rnd_pop_empty", {27'd0, rx_count}, 32'd0);
            end
            len = $urandom_range(1, DEPTH);
            while (DEPTH - rx_q.size() < len) pop_one();
            if ($urandom_range(0, 1)) begin
                o_valid = 1'b1; dout = 8'($urandom);
                tick();
                o_valid = 1'b0;
                chk("rnd_stray_drop", {27'd0, rx_count}, rx_q.size());
            end
            s.delete(); r.delete();
            for (int i = 0; i < len; i++) s.push_back(8'($urandom));
            for (int i = len - 1; i >= 0; i--) r.push_back(s[i]);
            load(s);
            send_burst(s);
            respond(r, 1'b1);
            chk("rnd_rx_count", {27'd0, rx_count}, rx_q.size());
            chk("rnd_rd_data", {24'd0, rd_data}, {24'd0, rx_q[0]});
            chk("rnd_mismatch", {31'd0, err_mismatch}, 32'd0);
        end
        chk("rnd_no_timeout", {31'd0, err_timeout}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
